sdram_arbiter: RTL and testbench

Shares one SDRAM core command port among NUM_REQ requesters. Each requester uses the core-port protocol: hold `wr`/`rd`, `addr` and `write_data` until `accept`, then later receive `ack` or `error`. The block sits between the requesters and the single SDRAM core controller. Responses come back in command order, and the block routes each one to its issuer through an internal ID FIFO.

---
 rtl/sdram_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arbiter
//  Purpose  : Shares one SDRAM core command port among NUM_REQ requesters.
//             A registered grant selects one requester and presents its
//             command to the core. Each accepted command pushes the issuer
//             ID into an in-order FIFO. Core responses pop that FIFO and are
//             routed to the issuer combinationally.
//  Ports    : clk, rst (async, active-high)
//             m_wr/m_rd/m_addr/m_write_data : per-requester commands
//                                            (slice i belongs to requester i)
//             m_accept/m_ack/m_error        : one-hot per-requester handshakes
//             m_read_data                   : core read data, gated by a
//                                            routed ack
//             s_wr/s_rd/s_addr/s_write_data : command to the core
//             s_accept/s_ack/s_error/s_read_data : core handshake/response
//             outstanding                   : ID FIFO occupancy
//  Config   : SDRAM_ARB_FIXED_PRIO_EN - when defined, the lowest requesting
//             index always wins and the round-robin pointer is removed.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WR_WIDTH   = $clog2(DATA_WIDTH) - 2,
  parameter int MAX_OUT    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*WR_WIDTH-1:0]    m_wr,
  input  logic [NUM_REQ-1:0]             m_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  m_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  m_write_data,
  output logic [NUM_REQ-1:0]             m_accept,
  output logic [NUM_REQ-1:0]             m_ack,
  output logic [NUM_REQ-1:0]             m_error,
  output logic [DATA_WIDTH-1:0]          m_read_data,
  output logic [WR_WIDTH-1:0]            s_wr,
  output logic                           s_rd,
  output logic [ADDR_WIDTH-1:0]          s_addr,
  output logic [DATA_WIDTH-1:0]          s_write_data,
  input  logic                           s_accept,
  input  logic                           s_ack,
  input  logic                           s_error,
  input  logic [DATA_WIDTH-1:0]          s_read_data,
  output logic [$clog2(MAX_OUT):0]       outstanding
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] fifo_q [MAX_OUT];

  logic [NUM_REQ-1:0] req;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Requester i is active when any write-enable bit or its read bit is set.
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign req[i] = (|m_wr[i*WR_WIDTH +: WR_WIDTH]) | m_rd[i];
    end
  endgenerate

  assign full  = (count_q == CNT_W'(MAX_OUT));
  assign empty = (count_q == '0);
  assign head  = fifo_q[rd_ptr_q];
  assign pop   = (s_ack | s_error) & ~empty;
  assign outstanding = count_q;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest requesting index is left standing.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[IDX_W'(i)]) winner = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  int               rr_idx;
  logic             rr_found;

  // Search begins one past the last accepted requester and wraps around,
  // so the most recently served requester has the lowest priority.
  always_comb begin
    winner   = '0;
    rr_idx   = 0;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = int'(last_grant_q) + k;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (!rr_found && req[IDX_W'(rr_idx)]) begin
        rr_found = 1'b1;
        winner   = IDX_W'(rr_idx);
      end
    end
  end

  assign last_grant_d = push ? grant_q : last_grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= IDX_W'(NUM_REQ - 1);
    else     last_grant_q <= last_grant_d;
  end
`endif

  // Grant FSM. Fullness is taken from the registered count, so a pop in
  // the same cycle cannot open the way for a grant until the next cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|req) && !full) begin
          grant_d = winner;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A requester that withdraws before acceptance loses its slot
        // without leaving an entry in the ID FIFO.
        if (!req[grant_q]) begin
          state_d = ST_IDLE;
        end else if (s_accept) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUT; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= grant_q;
    end
  end

  // Core command: driven only while a grant is held; zero in IDLE so no
  // requester input reaches the core without passing the grant register.
  always_comb begin
    s_wr         = '0;
    s_rd         = 1'b0;
    s_addr       = '0;
    s_write_data = '0;
    m_accept     = '0;
    if (state_q == ST_BUSY) begin
      s_wr         = m_wr[grant_q*WR_WIDTH +: WR_WIDTH];
      s_rd         = m_rd[grant_q];
      s_addr       = m_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
      s_write_data = m_write_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
      if (req[grant_q]) m_accept[grant_q] = s_accept;
    end
  end

  // Responses go to the FIFO head; with nothing outstanding they are dropped.
  always_comb begin
    m_ack       = '0;
    m_error     = '0;
    m_read_data = '0;
    if (pop) begin
      m_ack[head]   = s_ack;
      m_error[head] = s_error;
    end
    if (s_ack && !empty) m_read_data = s_read_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_arbiter
//  Purpose  : Directed self-checking bench for sdram_arbiter (2 requesters,
//             32-bit address/data, 4 outstanding).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WW = 3;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*WW-1:0]  m_wr;
  logic [NR-1:0]     m_rd;
  logic [NR*AW-1:0]  m_addr;
  logic [NR*DW-1:0]  m_write_data;
  logic [NR-1:0]     m_accept;
  logic [NR-1:0]     m_ack;
  logic [NR-1:0]     m_error;
  logic [DW-1:0]     m_read_data;
  logic [WW-1:0]     s_wr;
  logic              s_rd;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_write_data;
  logic              s_accept;
  logic              s_ack;
  logic              s_error;
  logic [DW-1:0]     s_read_data;
  logic [$clog2(MO):0] outstanding;

  int total = 0;
  int bad   = 0;
  int who;
  int exp_order [4];

  sdram_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WR_WIDTH   (WW),
    .MAX_OUT    (MO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .m_wr         (m_wr),
    .m_rd         (m_rd),
    .m_addr       (m_addr),
    .m_write_data (m_write_data),
    .m_accept     (m_accept),
    .m_ack        (m_ack),
    .m_error      (m_error),
    .m_read_data  (m_read_data),
    .s_wr         (s_wr),
    .s_rd         (s_rd),
    .s_addr       (s_addr),
    .s_write_data (s_write_data),
    .s_accept     (s_accept),
    .s_ack        (s_ack),
    .s_error      (s_error),
    .s_read_data  (s_read_data),
    .outstanding  (outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Bounded wait for a command at the core port; requester 1 always uses
  // addresses with bit 12 set, requester 0 with bit 12 clear.
  task automatic wait_cmd(output int w);
    logic found;
    found = 1'b0;
    w = -1;
    for (int k = 0; k < 8 && !found; k++) begin
      settle();
      if (s_rd || (s_wr != '0)) begin
        found = 1'b1;
        w = s_addr[12] ? 1 : 0;
      end else begin
        step();
      end
    end
    chk("cmd_seen", {63'd0, found}, 64'd1);
  endtask

  task automatic acc(input int exp_who, input string tag);
    int w;
    wait_cmd(w);
    chk({tag, "_who"}, 64'(w), 64'(exp_who));
    s_accept = 1'b1;
    settle();
    chk({tag, "_accept"}, 64'(m_accept), 64'(2'b01 << exp_who));
    step();
    s_accept = 1'b0;
  endtask

  task automatic ack(input logic [1:0] exp, input string tag);
    logic [DW-1:0] d;
    d = $urandom;
    s_ack = 1'b1;
    s_read_data = d;
    settle();
    chk({tag, "_ack"}, 64'(m_ack), 64'(exp));
    chk({tag, "_rdata"}, 64'(m_read_data), 64'(d));
    step();
    s_ack = 1'b0;
  endtask

  initial begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    rst = 1'b1;
    m_wr = '0; m_rd = '0; m_addr = '0; m_write_data = '0;
    s_accept = 1'b0; s_ack = 1'b0; s_error = 1'b0; s_read_data = '0;

    // Reset: activity on the inputs must not reach any output.
    step();
    m_rd = 2'b01; s_ack = 1'b1; s_read_data = 32'hFFFF_FFFF;
    settle();
    chk("rst_s_rd", 64'(s_rd), 64'd0);
    chk("rst_m_ack", 64'(m_ack), 64'd0);
    chk("rst_rdata", 64'(m_read_data), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    step();
    m_rd = '0; s_ack = 1'b0; s_read_data = '0;
    step();
    rst = 1'b0;

    // Fairness: both request continuously until the FIFO is full.
    m_rd = 2'b11;
    m_addr[0*AW +: AW] = 32'h0000_00A0;
    m_addr[1*AW +: AW] = 32'h0000_10B0;
    for (int n = 0; n < 4; n++) acc(exp_order[n], "fair");
    settle();
    chk("fair_full", 64'(outstanding), 64'd4);
    chk("fair_no_grant", 64'(s_rd), 64'd0);
    m_rd = '0;
    for (int n = 0; n < 4; n++) ack(2'b01 << exp_order[n], "fair_resp");
    settle();
    chk("fair_drained", 64'(outstanding), 64'd0);

    // Single read with exact cycle timing.
    step();
    m_rd[0] = 1'b1; m_addr[0*AW +: AW] = 32'h0000_0100;
    settle();
    chk("sr_idle_no_cmd", 64'(s_rd), 64'd0);
    step(); settle();
    chk("sr_s_rd", 64'(s_rd), 64'd1);
    chk("sr_s_addr", 64'(s_addr), 64'h100);
    chk("sr_no_accept", 64'(m_accept), 64'd0);
    step(); step();
    s_accept = 1'b1;
    settle();
    chk("sr_accept", 64'(m_accept), 64'd1);
    step();
    s_accept = 1'b0; m_rd = '0;
    settle();
    chk("sr_outstanding", 64'(outstanding), 64'd1);
    chk("sr_idle_after", 64'(s_rd), 64'd0);
    step(); step();
    s_ack = 1'b1; s_read_data = 32'hDEAD_BEEF;
    settle();
    chk("sr_m_ack", 64'(m_ack), 64'd1);
    chk("sr_rdata", 64'(m_read_data), 64'hDEAD_BEEF);
    step();
    s_ack = 1'b0;
    settle();
    chk("sr_outstanding0", 64'(outstanding), 64'd0);

    // Ordering: req1 read, req0 write, req1 read; responses follow issue order.
    step();
    m_rd[1] = 1'b1; m_addr[1*AW +: AW] = 32'h0000_1200;
    acc(1, "ord1");
    m_rd = '0;
    m_wr[0*WW +: WW] = 3'b101;
    m_write_data[0*DW +: DW] = 32'h1234_5678;
    m_addr[0*AW +: AW] = 32'h0000_0300;
    wait_cmd(who);
    chk("ord_wr_who", 64'(who), 64'd0);
    chk("ord_s_wr", 64'(s_wr), 64'd5);
    chk("ord_s_wdata", 64'(s_write_data), 64'h1234_5678);
    s_accept = 1'b1;
    settle();
    chk("ord_wr_accept", 64'(m_accept), 64'd1);
    step();
    s_accept = 1'b0; m_wr = '0;
    m_rd[1] = 1'b1;
    acc(1, "ord3");
    m_rd = '0;
    ack(2'b10, "ord_r1");
    ack(2'b01, "ord_r2");
    ack(2'b10, "ord_r3");

    // Full: a pending request is held off until a pop has registered.
    m_rd[0] = 1'b1; m_addr[0*AW +: AW] = 32'h0000_0400;
    for (int n = 0; n < 4; n++) acc(0, "full");
    m_rd = '0;
    m_rd[1] = 1'b1; m_addr[1*AW +: AW] = 32'h0000_1400;
    for (int n = 0; n < 3; n++) begin
      settle();
      chk("full_blocked", 64'(s_rd), 64'd0);
      chk("full_count", 64'(outstanding), 64'd4);
      step();
    end
    s_ack = 1'b1;
    settle();
    chk("full_pop_ack", 64'(m_ack), 64'd1);
    chk("full_pop_no_cmd", 64'(s_rd), 64'd0);
    step();
    s_ack = 1'b0;
    settle();
    chk("full_count3", 64'(outstanding), 64'd3);
    chk("full_idle_cycle", 64'(s_rd), 64'd0);
    step(); settle();
    chk("full_regrant", 64'(s_rd), 64'd1);
    chk("full_regrant_addr", 64'(s_addr), 64'h1400);
    s_accept = 1'b1;
    settle();
    chk("full_accept1", 64'(m_accept), 64'd2);
    step();
    s_accept = 1'b0; m_rd = '0;
    ack(2'b01, "full_d1");
    ack(2'b01, "full_d2");
    settle();
    chk("two_left", 64'(outstanding), 64'd2);

    // Push and pop together leave the occupancy unchanged.
    m_rd[0] = 1'b1; m_addr[0*AW +: AW] = 32'h0000_0500;
    wait_cmd(who);
    s_accept = 1'b1; s_ack = 1'b1;
    settle();
    chk("pp_accept", 64'(m_accept), 64'd1);
    chk("pp_ack", 64'(m_ack), 64'd1);
    step();
    s_accept = 1'b0; s_ack = 1'b0; m_rd = '0;
    settle();
    chk("pp_count", 64'(outstanding), 64'd2);
    s_error = 1'b1;
    settle();
    chk("err_m_error", 64'(m_error), 64'd2);
    chk("err_no_ack", 64'(m_ack), 64'd0);
    step();
    s_error = 1'b0;
    ack(2'b01, "pp_last");
    settle();
    chk("pp_empty", 64'(outstanding), 64'd0);

    // Orphan response.
    s_ack = 1'b1; s_read_data = 32'hCAFE_F00D;
    settle();
    chk("orphan_ack", 64'(m_ack), 64'd0);
    chk("orphan_rdata", 64'(m_read_data), 64'd0);
    step();
    s_ack = 1'b0;
    settle();
    chk("orphan_count", 64'(outstanding), 64'd0);

    // Reset while BUSY with three commands outstanding.
    m_rd[0] = 1'b1; m_addr[0*AW +: AW] = 32'h0000_0600;
    for (int n = 0; n < 3; n++) acc(0, "mrst");
    wait_cmd(who);
    chk("mrst_count3", 64'(outstanding), 64'd3);
    rst = 1'b1;
    #1;
    chk("mrst_s_rd", 64'(s_rd), 64'd0);
    chk("mrst_s_addr", 64'(s_addr), 64'd0);
    chk("mrst_count0", 64'(outstanding), 64'd0);
    m_rd = '0;
    step(); step();
    rst = 1'b0;
    s_ack = 1'b1;
    settle();
    chk("mrst_ack_ignored", 64'(m_ack), 64'd0);
    step();
    s_ack = 1'b0;
    // Pointer restored: requester 0 wins first again.
    m_rd = 2'b11;
    m_addr[0*AW +: AW] = 32'h0000_0700;
    m_addr[1*AW +: AW] = 32'h0000_1700;
    acc(0, "mrst_first");
    m_rd = '0;
    ack(2'b01, "mrst_resp");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
